// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// LOADER_CHECKSUM_EN enables the trailing XOR checksum byte and its state.
`timescale 1ns/1ps
package loader_pkg;

    localparam logic [7:0] LOADER_HEADER = 8'hA5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CNT_LO = 3'd1;
    localparam logic [2:0] ST_CNT_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_CNT_LO = ST_CNT_LO,
        S_CNT_HI = ST_CNT_HI,
        S_DATA   = ST_DATA,
        S_CSUM   = ST_CSUM,
        S_DONE   = ST_DONE,
        S_ERR    = ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_CHECKSUM = 2'b11
    } err_e;

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes little-endian into a 32-bit word and strobes word_valid
// for one cycle after the fourth byte.
`timescale 1ns/1ps
module word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] byte_cnt;

    // Shifting in from the top leaves the first byte in bits 7:0 after four bytes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt   <= 2'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= 2'd0;
            end else if (byte_valid) begin
                word       <= {byte_data, word[31:8]};
                byte_cnt   <= byte_cnt + 2'd1;
                word_valid <= (byte_cnt == 2'd3);
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART frame loader: A5, 16-bit word count, N little-endian words written to
// instruction memory; CPU held in reset until done. Optional LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_e            state, state_nxt;
    logic [1:0]        err_nxt;
    logic [15:0]       n_words;
    logic [15:0]       n_rx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              active;
    logic              frame_start;
    logic              reload_go;
    logic              last_write;
    logic              asm_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_acc;
`endif

    assign n_rx        = {rx_data, n_words[7:0]};
    assign active      = (state == S_CNT_LO) || (state == S_CNT_HI) ||
                         (state == S_DATA)   || (state == S_CSUM);
    assign tmo_hit     = !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
    assign frame_start = (state == S_IDLE) && rx_valid && (rx_data == LOADER_HEADER);
    assign reload_go   = ((state == S_DONE) || (state == S_ERR)) && reload;
    assign last_write  = imem_we && ((17'(words_loaded) + 17'd1) == {1'b0, n_words});
    assign asm_byte    = (state == S_DATA) && rx_valid;
    assign cpu_reset   = (state != S_DONE);
    assign done        = (state == S_DONE);

    word_assembler u_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (frame_start || reload_go),
        .byte_valid (asm_byte),
        .byte_data  (rx_data),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (rx_valid) begin
                    state_nxt = S_CNT_HI;
                end else if (tmo_hit) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            S_CNT_HI: begin
                if (rx_valid) begin
                    if ({1'b0, n_rx} > MAX_WORDS) begin
                        state_nxt = S_ERR;
                        err_nxt   = ERR_OVERFLOW;
                    end else if (n_rx == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_DATA;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            S_DATA: begin
                // Leave only once the final word has actually been written
                if (last_write) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
                end else if (tmo_hit) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_acc) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ERR;
                        err_nxt   = ERR_CHECKSUM;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_ERR;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (reload) begin
                    state_nxt = S_IDLE;
                    err_nxt   = ERR_NONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                err_nxt   = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_addr    <= '0;
            words_loaded <= '0;
        end else if (frame_start || reload_go) begin
            imem_addr    <= '0;
            words_loaded <= '0;
        end else if (imem_we) begin
            imem_addr    <= imem_addr + ADDR_W'(1);
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
        end
    end

    // Inter-byte watchdog only runs while a frame is in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            n_words <= 16'd0;
        end else begin
            if (!active || rx_valid) tmo_cnt <= '0;
            else                     tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state == S_CNT_LO && rx_valid) n_words[7:0]  <= rx_data;
            if (state == S_CNT_HI && rx_valid) n_words[15:8] <= rx_data;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_acc <= 8'd0;
        end else if (frame_start) begin
            csum_acc <= 8'd0;
        end else if (asm_byte) begin
            csum_acc <= csum_acc ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued by stimulus,
// popped by a write monitor; status outputs checked directly.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam int AW  = 4;
    localparam int TMO = 40;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          reload = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    int total = 0;
    int bad   = 0;
    logic [AW+31:0] exp_q[$];
    logic we_prev = 1'b0;

    prog_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (imem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%0h data=%08h, none expected", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    bad++;
                    $display("FAIL write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                             imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
                end
            end
            total++;
            if (we_prev) begin
                bad++;
                $display("FAIL we_width: got we high 2 cycles, expected 1");
            end
        end
        we_prev = imem_we;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input byte_q_t q);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic pulse_reload();
        @(posedge clk); #1;
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_err(input string name);
        int k;
        for (k = 0; k < TMO + 50; k++) begin
            @(negedge clk);
            if (err_code != 2'b00) break;
        end
        if (k == TMO + 50) begin
            total++;
            bad++;
            $display("FAIL %s: got no error within %0d cycles, expected one", name, TMO + 50);
        end
    endtask

    initial begin
        byte_q_t fr;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_words", words_loaded, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        settle(1);
        check("idle_cpu_reset", cpu_reset, 1);

        // Good two-word frame
        exp_q.push_back({4'd0, 32'h0000_0013});
        exp_q.push_back({4'd1, 32'h0010_0093});
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_frame(fr);
        settle(1);
`ifdef LOADER_CHECKSUM_EN
        check("t1_pre_csum_done", done, 0);
        check("t1_pre_csum_cpu_reset", cpu_reset, 1);
`else
        check("t1_no_csum_done", done, 1);
`endif
        send_byte(8'h90);
        settle(2);
        check("t1_done", done, 1);
        check("t1_cpu_reset", cpu_reset, 0);
        check("t1_words", words_loaded, 2);
        check("t1_err", err_code, 0);
        pulse_reload();
        settle(0);
        check("t1_reload_cpu_reset", cpu_reset, 1);
        check("t1_reload_words", words_loaded, 0);

        // Same frame, bad checksum byte
        exp_q.push_back({4'd0, 32'h0000_0013});
        exp_q.push_back({4'd1, 32'h0010_0093});
        send_frame(fr);
        send_byte(8'h91);
        settle(2);
`ifdef LOADER_CHECKSUM_EN
        check("t2_err", err_code, 3);
        check("t2_cpu_reset", cpu_reset, 1);
        check("t2_done", done, 0);
`else
        check("t2_err", err_code, 0);
        check("t2_done", done, 1);
`endif
        check("t2_words", words_loaded, 2);
        pulse_reload();
        settle(0);
        check("t2_reload_err", err_code, 0);
        check("t2_reload_cpu_reset", cpu_reset, 1);

        // Timeout after one word; reload mid-frame must be ignored
        exp_q.push_back({4'd0, 32'h0403_0201});
        fr = '{8'hA5, 8'h05, 8'h00, 8'h01, 8'h02};
        send_frame(fr);
        pulse_reload();
        fr = '{8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(fr);
        settle(1);
        check("t3_mid_err", err_code, 0);
        wait_err("t3_wait");
        check("t3_err", err_code, 1);
        check("t3_words", words_loaded, 1);
        check("t3_cpu_reset", cpu_reset, 1);
        pulse_reload();

        // Count one beyond memory depth
        fr = '{8'hA5, 8'h11, 8'h00};
        send_frame(fr);
        settle(2);
        check("t4_err", err_code, 2);
        check("t4_words", words_loaded, 0);
        check("t4_done", done, 0);
        pulse_reload();

        // Count exactly at memory depth is accepted, then times out
        fr = '{8'hA5, 8'h10, 8'h00};
        send_frame(fr);
        settle(2);
        check("t4b_err", err_code, 0);
        wait_err("t4b_wait");
        check("t4b_timeout", err_code, 1);
        pulse_reload();

        // Junk before header, zero-length frame
        fr = '{8'h00, 8'hFF};
        send_frame(fr);
        settle(1);
        check("t5_junk_done", done, 0);
        check("t5_junk_err", err_code, 0);
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        settle(2);
        check("t5_done", done, 1);
        check("t5_words", words_loaded, 0);
        check("t5_err", err_code, 0);

        // Header byte coinciding with reload is dropped
        @(posedge clk); #1;
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(posedge clk); #1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(fr);
        settle(2);
        check("t6_dropped_done", done, 0);
        check("t6_cpu_reset", cpu_reset, 1);

        // Reset mid-DATA aborts; a fresh frame then loads cleanly
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_frame(fr);
        @(posedge clk); #3;
        reset_n = 1'b0;
        @(negedge clk);
        check("t7_rst_cpu_reset", cpu_reset, 1);
        check("t7_rst_words", words_loaded, 0);
        check("t7_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.push_back({4'd0, 32'hDDCC_BBAA});
        fr = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_frame(fr);
        settle(2);
        check("t7_done", done, 1);
        check("t7_words", words_loaded, 1);
        check("t7_addr", imem_addr, 1);

        settle(2);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum idle cycles between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle strobe, byte received from UART RX.
REQ-006 SHALL have port rx_data, input, 8: received byte, valid only while rx_valid is high.
REQ-007 SHALL have port reload, input, 1: level input, request a new load.
REQ-008 SHALL have port imem_we, output, 1: instruction-memory write strobe.
REQ-009 SHALL have port imem_addr, output, ADDR_W: word address.
REQ-010 SHALL have port imem_wdata, output, 32: instruction word.
REQ-011 SHALL have port cpu_reset, output, 1: active-high hold of the CPU.
REQ-012 SHALL have port done, output, 1: load complete.
REQ-013 SHALL have port err_code, output, 2: 00 none, 01 timeout, 10 overflow, 11 checksum.
REQ-014 SHALL have port words_loaded, output, ADDR_W+1: count of words written.

Function
REQ-015 SHALL implement the states IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE and ERR.
REQ-016 In IDLE, byte 0xA5 SHALL move the FSM to CNT_LO; all other bytes SHALL be ignored.
REQ-017 CNT_LO and CNT_HI SHALL capture a 16-bit little-endian word count N, then go to DATA.
REQ-018 If N exceeds 2^ADDR_W, the FSM SHALL go to ERR with code 10 the cycle after CNT_HI.
REQ-019 If N is 0, the FSM SHALL go directly to CSUM, or to DONE when checksum is compiled out.
REQ-020 DATA SHALL assemble 4 bytes little-endian per word; the first byte is bits 7:0.
REQ-021 imem_we SHALL pulse for exactly 1 cycle, the cycle after the 4th byte of a word is accepted, with stable addr and wdata.
REQ-022 imem_addr SHALL start at 0 per frame and increment after each write; words_loaded SHALL increment with each write.
REQ-023 After the Nth write, the FSM SHALL go to CSUM (or DONE).
REQ-024 The timeout counter SHALL clear on every accepted byte and is active only in CNT_LO, CNT_HI, DATA and CSUM.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL go to ERR with code 01.
REQ-026 cpu_reset SHALL be 1 in every state except DONE; done SHALL be 1 only in DONE.
REQ-027 In DONE or ERR, reload=1 SHALL move the FSM to IDLE and clear err_code, words_loaded and the address; cpu_reset SHALL be 1 from the next cycle.
REQ-028 reload SHALL be ignored in all other states.
REQ-029 rx_valid in DONE or ERR SHALL be ignored; when rx_valid and reload coincide, reload wins and the byte is dropped.

Reset
REQ-030 While reset_n=0: state=IDLE, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err_code=00, words_loaded=0, all counters 0.
REQ-031 reset_n assertion mid-frame SHALL abort the frame immediately; words already written are not rolled back.

Configuration
REQ-032 With LOADER_CHECKSUM_EN defined, CSUM SHALL compare 1 byte against the XOR of all data bytes: match -> DONE, mismatch -> ERR with code 11.
REQ-033 Without LOADER_CHECKSUM_EN, the CSUM state and the XOR register SHALL be absent; the last write leads to DONE, and code 11 is never produced.

Structure
REQ-034 Package loader_pkg SHALL hold: state enum, err_code enum, and constant LOADER_HEADER=8'hA5.
REQ-035 Sub-module word_assembler SHALL implement the byte-lane shift register, byte counter and word-valid strobe.

Verification
REQ-036 Check frame A5 02 00 13 00 00 00 93 00 10 00 90: writes addr0=0x00000013 and addr1=0x00100093; done=1; cpu_reset 1->0; words_loaded=2.
REQ-037 Check the same frame with checksum byte 0x91: err_code=11, cpu_reset stays 1; reload -> IDLE, err_code=00.
REQ-038 Check A5 05 00 followed by 6 bytes then silence: after TIMEOUT_CYCLES, err_code=01 and exactly 1 write issued.
REQ-039 With ADDR_W=4, check A5 11 00: err_code=10, no imem_we.
REQ-040 Check junk 00 FF A5 00 00 00: junk ignored, done=1 with 0 writes; then reset_n pulse mid-DATA of a next frame -> IDLE, cpu_reset=1.
